// File: rtl/switch_led_arbiter_pkg.sv
// Shared types and constants for the two-requester switch/LED arbiter.
//   state_t : arbiter FSM states
//   owner_t : grant owner encoding (0 = requester 1, 1 = requester 2)
package switch_led_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_1 = 1'b0,
    OWNER_2 = 1'b1
  } owner_t;

  // Requester 2 is treated as the previous owner so requester 1 wins the first tie.
  localparam owner_t LAST_OWNER_RST = OWNER_2;

  // Larger of two unsigned values, for sizing shared counters.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser followed by a saturating-run debouncer for one raw switch.
//   i_clk    : system clock
//   i_rst    : synchronous active-high reset
//   i_switch : raw, asynchronous switch level
//   o_switch : debounced level (registered)
module switch_debounce
  import switch_led_arbiter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_switch,
  output logic o_switch
);

  localparam int unsigned        CNT_W    = cnt_width(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic             sync_1;
  logic             sync_2;
  logic             stable;
  logic [CNT_W-1:0] count;

  // Synchronise, then accept a new level only after DEBOUNCE_LIMIT consecutive disagreeing samples.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      stable <= 1'b0;
      count  <= '0;
    end else begin
      sync_1 <= i_switch;
      sync_2 <= sync_1;
      if (sync_2 == stable) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        stable <= sync_2;
        count  <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

  assign o_switch = stable;

endmodule

// File: rtl/switch_led_arbiter.sv
// Round-robin sharing of the LED resource between two debounced push switches.
//   i_clk      : system clock
//   i_rst      : synchronous active-high reset
//   i_switch_1 : raw switch, requester 1
//   i_switch_2 : raw switch, requester 2
//   o_led_1    : requester 1 holds the grant
//   o_led_2    : requester 2 holds the grant
//   o_led_3    : requester 1 pending
//   o_led_4    : requester 2 pending
//   o_busy     : arbiter in SERVE or GAP
module switch_led_arbiter
  import switch_led_arbiter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter int unsigned HOLD_CYCLES    = 12500000,
  parameter int unsigned GAP_CYCLES     = 2500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_switch_1,
  input  logic i_switch_2,
  output logic o_led_1,
  output logic o_led_2,
  output logic o_led_3,
  output logic o_led_4,
  output logic o_busy
);

  localparam int unsigned      TMR_W     = $clog2(max_u(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);

  logic             stable_1;
  logic             stable_2;
  logic             stable_q_1;
  logic             stable_q_2;
  logic             rise_1;
  logic             rise_2;

  logic             pending_1;
  logic             pending_2;
  logic             pending_1_nxt;
  logic             pending_2_nxt;
  logic             grant_1;
  logic             grant_2;

  state_t           state;
  state_t           state_nxt;
  owner_t           owner;
  owner_t           owner_nxt;
  owner_t           last_owner;
  owner_t           last_owner_nxt;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_nxt;

  logic             led_1_nxt;
  logic             led_2_nxt;
  logic             busy_nxt;

  // Per-switch synchroniser and debouncer.
  switch_debounce #(
    .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
  ) u_debounce_1 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_switch(i_switch_1),
    .o_switch(stable_1)
  );

  switch_debounce #(
    .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
  ) u_debounce_2 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_switch(i_switch_2),
    .o_switch(stable_2)
  );

  // Press events: debounced rising edges only; releases are ignored.
  assign rise_1 = stable_1 & ~stable_q_1;
  assign rise_2 = stable_2 & ~stable_q_2;

  // Next-state, grant, pending and output decode.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    timer_nxt      = timer;
    grant_1        = 1'b0;
    grant_2        = 1'b0;

    case (state)
      IDLE: begin
        // On a tie the requester that did not own the LED last time wins.
        if (pending_1 && (!pending_2 || (last_owner == OWNER_2))) begin
          grant_1 = 1'b1;
        end else if (pending_2) begin
          grant_2 = 1'b1;
        end
        if (grant_1 || grant_2) begin
          owner_nxt      = grant_1 ? OWNER_1 : OWNER_2;
          last_owner_nxt = grant_1 ? OWNER_1 : OWNER_2;
          timer_nxt      = '0;
          state_nxt      = SERVE;
        end
      end
      SERVE: begin
        if (timer == HOLD_LAST) begin
          timer_nxt = '0;
          state_nxt = GAP;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      GAP: begin
        if (timer == GAP_LAST) begin
          timer_nxt = '0;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      default: begin
        timer_nxt = '0;
        state_nxt = IDLE;
      end
    endcase

    // A press on the grant edge re-queues the request.
    pending_1_nxt = rise_1 | (pending_1 & ~grant_1);
    pending_2_nxt = rise_2 | (pending_2 & ~grant_2);

    led_1_nxt = (state_nxt == SERVE) && (owner_nxt == OWNER_1);
    led_2_nxt = (state_nxt == SERVE) && (owner_nxt == OWNER_2);
    busy_nxt  = (state_nxt != IDLE);
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      owner      <= OWNER_1;
      last_owner <= LAST_OWNER_RST;
      timer      <= '0;
      pending_1  <= 1'b0;
      pending_2  <= 1'b0;
      stable_q_1 <= 1'b0;
      stable_q_2 <= 1'b0;
      o_led_1    <= 1'b0;
      o_led_2    <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      timer      <= timer_nxt;
      pending_1  <= pending_1_nxt;
      pending_2  <= pending_2_nxt;
      stable_q_1 <= stable_1;
      stable_q_2 <= stable_2;
      o_led_1    <= led_1_nxt;
      o_led_2    <= led_2_nxt;
      o_busy     <= busy_nxt;
    end
  end

  assign o_led_3 = pending_1;
  assign o_led_4 = pending_2;

endmodule

// File: doc/switch_led_arbiter.md
Name: switch_led_arbiter

Overview:
- Shares the board's LED resource between two push-switch requesters.
- Each raw switch is debounced, and each press is latched as a pending request.
- A round-robin FSM grants the LED to one requester at a time for a fixed hold window, then enforces an off gap.
- Sits between the board switch pins and the LED pins. It is the sequencing layer above the plain switch-to-LED logic.

Parameters:
- DEBOUNCE_LIMIT, 250000: consecutive cycles a raw switch must differ from its debounced level before that level updates (10 ms at 25 MHz).
- HOLD_CYCLES, 12500000: cycles the granted LED stays on (0.5 s at 25 MHz). Must be >= 1.
- GAP_CYCLES, 2500000: cycles all grant LEDs stay off between grants. Must be >= 1.

Ports:
- i_clk, input, 1: system clock. Single clock domain.
- i_rst, input, 1: synchronous, active-high reset.
- i_switch_1, input, 1: raw switch 1, asynchronous to i_clk (2-flop synchronised inside).
- i_switch_2, input, 1: raw switch 2, as above.
- o_led_1, output, 1: high while requester 1 holds the grant.
- o_led_2, output, 1: high while requester 2 holds the grant.
- o_led_3, output, 1: requester 1 pending flag.
- o_led_4, output, 1: requester 2 pending flag.
- o_busy, output, 1: high in SERVE or GAP.

Behaviour:
- Reset (i_rst sampled high at a clock edge):
  - All outputs 0; state IDLE.
  - Pending flags, counters and debounced levels cleared to 0.
  - last_owner set to 2, so requester 1 wins the first tie.
  - Reset mid-SERVE or mid-GAP aborts immediately; outputs are 0 after that edge.
- Synchroniser: 2 flops per switch. The debouncer sees the synchronised value.
- Debounce (per switch):
  - Counter increments each cycle while sync != stable, and clears whenever sync == stable.
  - On the edge where count == DEBOUNCE_LIMIT-1: stable <= sync, count <= 0.
  - Counter width is $clog2(DEBOUNCE_LIMIT).
- Press detect: rise = stable & ~stable_q, registered one cycle. Release events are ignored.
- Pending flag (per requester):
  - Set on rise; cleared on the edge its grant is issued.
  - If set and clear occur in the same cycle, set wins: the request re-queues.
  - A press during the requester's own SERVE or GAP re-queues it.
  - Presses while already pending are absorbed; there is no count.
- FSM states: IDLE, SERVE, GAP.
  - IDLE: if exactly one pending, grant it. If both pending, grant the requester != last_owner. On grant: owner <= r, last_owner <= r, timer <= 0, go to SERVE. If none pending, stay.
  - SERVE: timer increments. When timer == HOLD_CYCLES-1, timer <= 0 and go to GAP.
  - GAP: timer increments. When timer == GAP_CYCLES-1, go to IDLE.
- Timer width: $clog2(max(HOLD_CYCLES, GAP_CYCLES)+1).
- Outputs:
  - o_led_1/o_led_2 = (state == SERVE) && owner == 1/2. Registered, glitch-free.
  - o_led_3/o_led_4 = pending flags.
  - o_busy = state != IDLE.
- Latency (from the edge where debounced stable rises, idle arbiter):
  - Pending visible 1 cycle later.
  - Grant LED visible 2 cycles later.
  - LED high for exactly HOLD_CYCLES cycles.
  - Then low for exactly GAP_CYCLES cycles before the next grant can begin.
- Both requesters pending continuously: grants strictly alternate 1, 2, 1, 2.
- Switch held permanently: exactly one request, because only rising edges count.

Decomposition:
- Package switch_led_arbiter_pkg:
  - state_t enum {IDLE, SERVE, GAP}.
  - owner_t (1-bit: 0 = requester 1, 1 = requester 2).
  - Reset constant for last_owner.
- Sub-module switch_debounce (parameter DEBOUNCE_LIMIT; ports i_clk, i_rst, i_switch, o_switch):
  - Contains the synchroniser and debounce counter.
  - Instantiated twice.
- Edge detect, pending flags and FSM live in the top module.

Test Plan (DEBOUNCE_LIMIT=4, HOLD_CYCLES=8, GAP_CYCLES=2):
1. Reset: assert i_rst 3 cycles with switches toggling -> all five outputs 0 throughout, and 0 on the first cycle after release.
2. Glitch: i_switch_1 high 3 cycles then low -> o_led_3 and o_led_1 never assert, o_busy stays 0.
3. Single press: i_switch_1 high 20 cycles -> o_led_3 pulses, o_led_1 high exactly 8 consecutive cycles, then o_busy high 2 more cycles, then 0. o_led_2 stays 0.
4. Simultaneous press after reset: both switches rise on the same edge -> o_led_1 8 cycles, gap 2, o_led_2 8 cycles. o_led_4 stays high until requester 2's grant edge.
5. Round robin: requester 1 served, then both pressed during its GAP -> requester 2 granted first, then requester 1.
6. Reset mid-operation: assert i_rst at SERVE cycle 4 with requester 2 pending -> next cycle o_led_1=0, o_led_4=0, o_busy=0. No grant follows without a new press.
